// File: rtl/pong_pkg.sv
// Shared types for the Pong match controller.
// match_state_t : 3-bit match FSM state, exported on matchState.
// winner_t      : 2-bit winner code (00 none, 01 player 1, 10 player 2).
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StPoint  = 3'd3,
    StPaused = 3'd4,
    StOver   = 3'd5
  } match_state_t;

  typedef enum logic [1:0] {
    WinNone = 2'b00,
    WinP1   = 2'b01,
    WinP2   = 2'b10
  } winner_t;

  localparam winner_t WINNER_NONE = WinNone;
  localparam winner_t WINNER_P1   = WinP1;
  localparam winner_t WINNER_P2   = WinP2;

endpackage

// File: rtl/pong_match_controller_if.sv
// Bundle of frame strobe, buttons, engine events and match status between the
// pixel/engine side (master) and the match controller (slave).
//   master : drives pixIf_NEXT_FRAME, startBtn, pauseBtn, player1Missed,
//            player2Missed; observes controller outputs.
//   slave  : the controller; consumes the above, drives engineStep,
//            engineResetPos, serveToPlayer2, scores, matchState, winner.
interface pong_match_controller_if #(
  parameter int unsigned SCORE_WIDTH = 4
);
  import pong_pkg::*;

  logic                   pixIf_NEXT_FRAME;
  logic                   startBtn;
  logic                   pauseBtn;
  logic                   player1Missed;
  logic                   player2Missed;
  logic                   engineStep;
  logic                   engineResetPos;
  logic                   serveToPlayer2;
  logic [SCORE_WIDTH-1:0] player1Score;
  logic [SCORE_WIDTH-1:0] player2Score;
  match_state_t           matchState;
  logic [1:0]             winner;

  modport master (
    output pixIf_NEXT_FRAME, startBtn, pauseBtn, player1Missed, player2Missed,
    input  engineStep, engineResetPos, serveToPlayer2, player1Score, player2Score,
           matchState, winner
  );

  modport slave (
    input  pixIf_NEXT_FRAME, startBtn, pauseBtn, player1Missed, player2Missed,
    output engineStep, engineResetPos, serveToPlayer2, player1Score, player2Score,
           matchState, winner
  );

endinterface

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter.
//   clk, rst_n  : clock, synchronous active-low reset (count -> 0)
//   load        : load loadValue (has priority over counting)
//   loadValue   : value to load
//   frameStrobe : decrement by one when not frozen and count is non-zero
//   freeze      : hold the count
//   expire      : count is 1 and an unfrozen strobe arrives this cycle
module pong_frame_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             frameStrobe,
  input  logic             freeze,
  output logic             expire
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick;

  assign tick   = frameStrobe & ~freeze;
  assign expire = tick & (count_q == WIDTH'(1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = loadValue;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: gates the engine frame step, keeps scores, inserts
// serve delay / point hold, and declares the winner.
//   pixIf_CLK, pixIf_RST_N : pixel clock, synchronous active-low reset
//   bus (slave modport)    : frame strobe, buttons, miss pulses in;
//                            engine controls, scores, state, winner out
// Optional feature: define PONG_PAUSE_EN to build pause/resume on pauseBtn.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int unsigned SCORE_LIMIT        = 9,
  parameter int unsigned SCORE_WIDTH        = 4,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned POINT_HOLD_FRAMES  = 30,
  parameter int unsigned FRAME_CNT_WIDTH    = 7
) (
  input logic                    pixIf_CLK,
  input logic                    pixIf_RST_N,
  pong_match_controller_if.slave bus
);

  localparam logic [SCORE_WIDTH-1:0]     Limit = SCORE_WIDTH'(SCORE_LIMIT);
  localparam logic [FRAME_CNT_WIDTH-1:0] ServeLoad = FRAME_CNT_WIDTH'(SERVE_DELAY_FRAMES);
  localparam logic [FRAME_CNT_WIDTH-1:0] HoldLoad  = FRAME_CNT_WIDTH'(POINT_HOLD_FRAMES);

  match_state_t           state_q, state_d;
  logic [SCORE_WIDTH-1:0] p1_score_q, p1_score_d;
  logic [SCORE_WIDTH-1:0] p2_score_q, p2_score_d;
  winner_t                winner_q, winner_d;
  logic                   serve_p2_q, serve_p2_d;
  logic                   reset_pos_q, reset_pos_d;
  logic                   start_q;
  logic                   start_edge;

  logic                       timer_load;
  logic [FRAME_CNT_WIDTH-1:0] timer_value;
  logic                       timer_expire;
  logic                       timer_strobe;

  assign start_edge = bus.startBtn & ~start_q;

`ifdef PONG_PAUSE_EN
  logic         pause_q;
  logic         pause_edge;
  match_state_t saved_q, saved_d;

  assign pause_edge = bus.pauseBtn & ~pause_q;

  always_ff @(posedge pixIf_CLK) begin
    if (!pixIf_RST_N) begin
      pause_q <= 1'b0;
      saved_q <= StIdle;
    end else begin
      pause_q <= bus.pauseBtn;
      saved_q <= saved_d;
    end
  end
`else
  logic unused_pause_btn;
  assign unused_pause_btn = bus.pauseBtn;
`endif

  // Only SERVE and POINT consume frames; elsewhere the timer sits at 0.
  assign timer_strobe = bus.pixIf_NEXT_FRAME & ((state_q == StServe) | (state_q == StPoint));

  pong_frame_timer #(
    .WIDTH(FRAME_CNT_WIDTH)
  ) u_timer (
    .clk        (pixIf_CLK),
    .rst_n      (pixIf_RST_N),
    .load       (timer_load),
    .loadValue  (timer_value),
    .frameStrobe(timer_strobe),
    .freeze     (state_q == StPaused),
    .expire     (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    winner_d    = winner_q;
    serve_p2_d  = serve_p2_q;
    reset_pos_d = 1'b0;
    timer_load  = 1'b0;
    timer_value = ServeLoad;
`ifdef PONG_PAUSE_EN
    saved_d     = saved_q;
`endif

    if (start_edge) begin
      // Start (re)initialises the match from any state and beats pause.
      p1_score_d  = '0;
      p2_score_d  = '0;
      winner_d    = WINNER_NONE;
      serve_p2_d  = 1'b0;
      reset_pos_d = 1'b1;
      timer_load  = 1'b1;
      timer_value = ServeLoad;
      state_d     = StServe;
`ifdef PONG_PAUSE_EN
    end else if (pause_edge &&
                 (state_q == StServe || state_q == StPlay || state_q == StPoint)) begin
      saved_d = state_q;
      state_d = StPaused;
    end else if (pause_edge && state_q == StPaused) begin
      state_d = saved_q;
`endif
    end else begin
      unique case (state_q)
        StServe: begin
          if (timer_expire) state_d = StPlay;
        end
        StPlay: begin
          if (bus.player1Missed || bus.player2Missed) begin
            timer_load  = 1'b1;
            timer_value = HoldLoad;
            state_d     = StPoint;
            // A simultaneous double miss scores nothing.
            if (bus.player1Missed && !bus.player2Missed) begin
              if (p2_score_q < Limit) p2_score_d = p2_score_q + SCORE_WIDTH'(1);
              serve_p2_d = 1'b0;
            end else if (bus.player2Missed && !bus.player1Missed) begin
              if (p1_score_q < Limit) p1_score_d = p1_score_q + SCORE_WIDTH'(1);
              serve_p2_d = 1'b1;
            end
          end
        end
        StPoint: begin
          if (timer_expire) begin
            if (p1_score_q == Limit) begin
              winner_d = WINNER_P1;
              state_d  = StOver;
            end else if (p2_score_q == Limit) begin
              winner_d = WINNER_P2;
              state_d  = StOver;
            end else begin
              reset_pos_d = 1'b1;
              timer_load  = 1'b1;
              timer_value = ServeLoad;
              state_d     = StServe;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixIf_CLK) begin
    if (!pixIf_RST_N) begin
      state_q     <= StIdle;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      winner_q    <= WINNER_NONE;
      serve_p2_q  <= 1'b0;
      reset_pos_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      winner_q    <= winner_d;
      serve_p2_q  <= serve_p2_d;
      reset_pos_q <= reset_pos_d;
      start_q     <= bus.startBtn;
    end
  end

  assign bus.engineStep     = bus.pixIf_NEXT_FRAME & (state_q == StPlay);
  assign bus.engineResetPos = reset_pos_q;
  assign bus.serveToPlayer2 = serve_p2_q;
  assign bus.player1Score   = p1_score_q;
  assign bus.player2Score   = p2_score_q;
  assign bus.matchState     = state_q;
  assign bus.winner         = winner_q;

endmodule
